// File: rtl/sonar_pkg.sv
// Shared types and default timing for the HC-SR04-style sonar driver.
`default_nettype none

package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int UNIT_CYCLES_DEF    = 2900;
  localparam int TIMEOUT_CYCLES_DEF = 1900000;

  localparam logic [7:0] DIST_MAX = 8'hFF;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TRIG_W_DEF = cnt_width(TRIG_CYCLES_DEF);
  localparam int UNIT_W_DEF = cnt_width(UNIT_CYCLES_DEF);
  localparam int TMO_W_DEF  = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

`default_nettype wire

// File: rtl/sonar_echo_sync.sv
// Two-flop synchroniser bringing the raw echo pin into the clk domain.
`default_nettype none

module sonar_echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/sonar_driver.sv
// Turns a measure request into a trigger pulse, times the echo and reports
// a saturated 8-bit distance with a one-cycle ready strobe.
`default_nettype none

module sonar_driver
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int UNIT_CYCLES    = UNIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sonar_measure,
  input  logic       i_echo,
  output logic       o_trig,
  output logic       o_sonar_ready,
  output logic [7:0] o_sonar_distance
);

  localparam int TRIG_W = cnt_width(TRIG_CYCLES);
  localparam int UNIT_W = cnt_width(UNIT_CYCLES);
  localparam int TMO_W  = cnt_width(TIMEOUT_CYCLES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_echo_s;
  logic                r_meas_prev;
  logic [TRIG_W-1:0]   r_trig_cnt;
  logic [UNIT_W-1:0]   r_presc;
  logic [TMO_W-1:0]    r_tmo;
  logic [7:0]          r_dist_cnt;
  logic                r_armed;
  logic                r_trig;
  logic                r_ready;
  logic [7:0]          r_distance;
  logic [7:0]          w_result;
  logic                w_start;
  logic                w_trig_end;
  logic                w_tmo_hit;
  logic                w_rise;
  logic                w_count;

  sonar_echo_sync u_echo_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_echo),
    .o_sync  (w_echo_s)
  );

  assign w_start    = i_sonar_measure & ~r_meas_prev;
  assign w_trig_end = (r_trig_cnt == TRIG_W'(TRIG_CYCLES - 1));
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  // A rise only counts once echo has been seen low, so a still-busy sensor is skipped.
  assign w_rise     = r_armed & w_echo_s;
  assign w_count    = ((r_state == MEASURE) && w_echo_s) ||
                      ((r_state == WAIT_RISE) && w_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_result    = r_dist_cnt;
    case (r_state)
      IDLE:      if (w_start) w_state_nxt = TRIG;
      TRIG:      if (w_trig_end) w_state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        if (w_tmo_hit) begin
          w_state_nxt = DONE;
          w_result    = DIST_MAX;
        end else if (w_rise) begin
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (w_tmo_hit) begin
          w_state_nxt = DONE;
          w_result    = DIST_MAX;
        end else if (!w_echo_s) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_prev <= 1'b0;
      r_trig_cnt  <= '0;
      r_presc     <= '0;
      r_tmo       <= '0;
      r_dist_cnt  <= '0;
      r_armed     <= 1'b0;
      r_trig      <= 1'b0;
      r_ready     <= 1'b0;
      r_distance  <= '0;
    end else begin
      r_meas_prev <= i_sonar_measure;
      r_trig      <= (w_state_nxt == TRIG);
      r_ready     <= (w_state_nxt == DONE);

      if ((r_state == IDLE) && w_start) begin
        r_trig_cnt <= '0;
        r_presc    <= '0;
        r_tmo      <= '0;
        r_dist_cnt <= '0;
        r_armed    <= 1'b0;
      end

      if (r_state == TRIG) begin
        r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
      end

      if ((r_state == WAIT_RISE) || (r_state == MEASURE)) begin
        r_tmo   <= r_tmo + TMO_W'(1);
        r_armed <= r_armed | ~w_echo_s;
      end

      if (w_count) begin
        if (r_presc == UNIT_W'(UNIT_CYCLES - 1)) begin
          r_presc <= '0;
          if (r_dist_cnt != DIST_MAX) r_dist_cnt <= r_dist_cnt + 8'd1;
        end else begin
          r_presc <= r_presc + UNIT_W'(1);
        end
      end

      if (w_state_nxt == DONE) begin
        r_distance <= w_result;
      end
    end
  end

  assign o_trig           = r_trig;
  assign o_sonar_ready    = r_ready;
  assign o_sonar_distance = r_distance;

endmodule

`default_nettype wire

// File: tb/tb_sonar_driver.sv
// Directed self-checking bench for sonar_driver with shortened timing.
`default_nettype none

module tb_sonar_driver;

  logic       clk;
  logic       rst_n;
  logic       i_sonar_measure;
  logic       i_echo;
  logic       o_trig;
  logic       o_sonar_ready;
  logic [7:0] o_sonar_distance;

  int errors = 0;
  int checks = 0;
  int ready_cnt = 0;
  int trig_cnt = 0;
  logic trig_q = 1'b0;

  sonar_driver #(
    .TRIG_CYCLES    (4),
    .UNIT_CYCLES    (10),
    .TIMEOUT_CYCLES (3000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_sonar_measure  (i_sonar_measure),
    .i_echo           (i_echo),
    .o_trig           (o_trig),
    .o_sonar_ready    (o_sonar_ready),
    .o_sonar_distance (o_sonar_distance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_sonar_ready) ready_cnt++;
    if (o_trig && !trig_q) trig_cnt++;
    trig_q = o_trig;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_measure();
    @(negedge clk) i_sonar_measure = 1'b1;
    @(negedge clk) i_sonar_measure = 1'b0;
  endtask

  // Returns the number of negedges with trig high; ends on the first low one.
  task automatic wait_trig(output int hi);
    hi = 0;
    while (o_trig && hi < 100) begin
      hi++;
      @(negedge clk);
    end
  endtask

  // Counts posedges until ready is seen #1 after one; ends just after that edge.
  task automatic wait_ready(input int bound, output int e);
    e = 0;
    do begin
      @(posedge clk);
      #1;
      e++;
    end while (!o_sonar_ready && e < bound);
  endtask

  task automatic echo_high(input int n);
    i_echo = 1'b1;
    repeat (n) @(negedge clk);
    i_echo = 1'b0;
  endtask

  initial begin
    int hi, e, rc0, tc0;

    rst_n = 1'b0;
    i_echo = 1'b1;
    i_sonar_measure = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig", o_trig, 0);
    check("rst_ready", o_sonar_ready, 0);
    check("rst_dist", o_sonar_distance, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    i_echo = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_trig", trig_cnt, 0);
    check("idle_no_ready", ready_cnt, 0);

    // Basic measurement: 253 high cycles -> 25 units.
    rc0 = ready_cnt;
    pulse_measure();
    wait_trig(hi);
    check("basic_trig_width", hi, 4);
    repeat (20) @(negedge clk);
    echo_high(253);
    wait_ready(20, e);
    check("basic_ready_latency", e, 3);
    check("basic_dist", o_sonar_distance, 25);
    @(posedge clk); #1;
    check("basic_ready_strobe", o_sonar_ready, 0);
    @(negedge clk);
    check("basic_strobe_count", ready_cnt - rc0, 1);

    // Saturation.
    rc0 = ready_cnt;
    pulse_measure();
    wait_trig(hi);
    repeat (10) @(negedge clk);
    echo_high(2800);
    wait_ready(20, e);
    check("sat_dist", o_sonar_distance, 255);
    repeat (5) @(negedge clk);
    check("sat_strobe_count", ready_cnt - rc0, 1);

    // No echo: timeout exactly 3000 cycles after trig falls.
    pulse_measure();
    wait_trig(hi);
    wait_ready(3100, e);
    check("tmo_latency", e, 3000);
    check("tmo_dist", o_sonar_distance, 255);

    // Request during MEASURE is ignored.
    repeat (5) @(negedge clk);
    rc0 = ready_cnt;
    tc0 = trig_cnt;
    pulse_measure();
    wait_trig(hi);
    repeat (5) @(negedge clk);
    i_echo = 1'b1;
    repeat (30) @(negedge clk);
    pulse_measure();
    repeat (68) @(negedge clk);
    i_echo = 1'b0;
    wait_ready(20, e);
    check("filt_dist", o_sonar_distance, 10);
    repeat (20) @(negedge clk);
    check("filt_strobe_count", ready_cnt - rc0, 1);
    check("filt_trig_count", trig_cnt - tc0, 1);

    // Held-high request triggers exactly once.
    rc0 = ready_cnt;
    tc0 = trig_cnt;
    @(negedge clk) i_sonar_measure = 1'b1;
    repeat (10000) @(negedge clk);
    i_sonar_measure = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_trig_count", trig_cnt - tc0, 1);
    check("hold_strobe_count", ready_cnt - rc0, 1);
    check("hold_dist", o_sonar_distance, 255);

    // Reset in the middle of MEASURE.
    rc0 = ready_cnt;
    pulse_measure();
    wait_trig(hi);
    repeat (5) @(negedge clk);
    i_echo = 1'b1;
    repeat (55) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_trig", o_trig, 0);
    check("mrst_ready", o_sonar_ready, 0);
    check("mrst_dist", o_sonar_distance, 0);
    repeat (3) @(negedge clk);
    i_echo = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mrst_no_strobe", ready_cnt - rc0, 0);
    pulse_measure();
    wait_trig(hi);
    repeat (7) @(negedge clk);
    echo_high(47);
    wait_ready(20, e);
    check("mrst_after_dist", o_sonar_distance, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
